alu_result_checker: RTL and testbench
=====================================

Name: alu_result_checker

Overview:
- Response-side counterpart to the ALU stimulus generator.
- Queues expected results and operation flags from the stimulus side, then compares each DUT result, in order, against the oldest queued expectation.
- Keeps pass/fail counts, captures the first mismatch and flags protocol errors.
- Synthesizable, so it can sit in the bench or on-chip behind the ALU for self-test.

Parameters:
- WIDTH, 32, operand width; results are WIDTH+1 bits (carry/borrow in MSB).
- DEPTH, 4, expectation FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the pass/fail counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear of FIFO, counters, flags and state
- exp_valid  in  1  expectation present this cycle
- exp_result  in  WIDTH+1  expected result
- exp_add  in  1  op is add
- exp_sub  in  1  op is sub
- exp_cmp  in  1  op is cmp
- exp_ready  out  1  FIFO can accept (not full and not halted)
- dut_valid  in  1  DUT result present this cycle
- dut_result  in  WIDTH+1  DUT result
- pass_count  out  CNT_W  matches, saturating
- fail_count  out  CNT_W  mismatches, saturating
- mismatch  out  1  one-cycle pulse on a failed compare
- first_fail_exp  out  WIDTH+1  expected value of the first failure
- first_fail_dut  out  WIDTH+1  DUT value of the first failure
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: dut_valid while FIFO empty
- halted  out  1  checker is in HALT

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0 except exp_ready=1; FIFO empty; state RUN.
- clear has the same effect as reset but is synchronous. clear has priority over all other inputs in that cycle.
- Push: exp_valid && exp_ready stores {exp_result, exp_add, exp_sub, exp_cmp} at the write pointer.
- Push while full (exp_valid && full, RUN): entry dropped, overflow set.
- Pop: dut_valid in RUN with the FIFO non-empty pops the head and compares it against dut_result.
- Simultaneous push and pop when full: both allowed; occupancy is unchanged. exp_ready is computed from registered occupancy, so it stays 0 that cycle.
- No bypass: with the FIFO empty, dut_valid is an underflow even if exp_valid is high the same cycle. Underflow sets underflow, increments fail_count and pulses mismatch. The push still proceeds.
- Pointers are log2(DEPTH) bits and wrap naturally. An extra occupancy counter (0..DEPTH) gives full and empty.
- Compare rules, by head flags:
  - add or sub: all WIDTH+1 bits must match.
  - cmp: only bit WIDTH (borrow) and the zero flag (low WIDTH bits all zero) must match.
  - All flags 0: treated as sub.
  - Multiple flags set: priority add > sub > cmp.
- Latency: the compare is registered. pass_count, fail_count and mismatch update on the edge after the pop edge, i.e. one cycle after dut_valid is sampled.
- On the first failure (fail_count == 0 beforehand), capture first_fail_exp and first_fail_dut. On an underflow failure, first_fail_exp is captured as 0. Later failures never overwrite the capture.
- Counters saturate at all-ones.
- State machine:
  - RUN: normal operation.
  - HALT: entered only with the optional feature enabled. In HALT, exp_ready=0, pushes and pops are ignored, counters are frozen and halted=1. Only clear or reset returns to RUN.
- Reset mid-operation: rst_n asserted with entries queued discards them immediately; nothing is counted.

Optional Feature:
- Macro: CHK_STOP_ON_FAIL_EN.
- Defined: the registered compare result that raises mismatch also moves the state to HALT on the same edge. The failing compare itself is counted. Entries still in the FIFO are retained, visible for debug.
- Undefined: the HALT state is not built, halted is tied to 0, and the checker runs through all failures.

Test Plan:
- Push 3 adds (exp 0x0_00000003, 0x1_00000000, 0x0_FFFFFFFF), then three dut_valid with equal values -> pass_count=3, fail_count=0, mismatch never pulses, FIFO empty.
- Push a sub expecting 0x1_FFFFFFFF; DUT returns 0x0_FFFFFFFF -> mismatch pulses one cycle after dut_valid, fail_count=1, first_fail_exp=0x1_FFFFFFFF, first_fail_dut=0x0_FFFFFFFF. A second failure leaves the capture unchanged.
- Push a cmp expecting 0x1_00000005; DUT returns 0x1_00000009 -> pass (borrow equal, both non-zero). DUT returning 0x1_00000000 instead -> fail.
- Push 5 with DEPTH=4 and no pops -> exp_ready=0 after 4 pushes, overflow=1, 4 entries retained. Then push and pop in the same cycle while full -> occupancy stays 4.
- dut_valid with the FIFO empty and exp_valid high the same cycle -> underflow=1, fail_count=1, entry queued (occupancy 1).
- With CHK_STOP_ON_FAIL_EN: fail, then 2 more dut_valid -> halted=1, fail_count=1, pass_count unchanged. Pulse clear -> halted=0, counters 0. Also assert rst_n=0 mid-queue -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/alu_result_checker.sv
// In-order checker for ALU results against queued expectations, with pass/fail counters and first-failure capture.
// Optional stop-on-first-failure HALT state is built when CHK_STOP_ON_FAIL_EN is defined.
module alu_result_checker #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             exp_valid,
  input  logic [WIDTH:0]   exp_result,
  input  logic             exp_add,
  input  logic             exp_sub,
  input  logic             exp_cmp,
  output logic             exp_ready,
  input  logic             dut_valid,
  input  logic [WIDTH:0]   dut_result,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             mismatch,
  output logic [WIDTH:0]   first_fail_exp,
  output logic [WIDTH:0]   first_fail_dut,
  output logic             overflow,
  output logic             underflow,
  output logic             halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int EW = WIDTH + 4;
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [EW-1:0]    fifo_mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [OW-1:0]    occ_q;
  logic             full, empty;
  logic [WIDTH:0]   head_result;
  logic [2:0]       head_flags;

  logic             cmp_vld_q, cmp_uf_q;
  logic [WIDTH:0]   cmp_exp_q, cmp_dut_q;
  logic [2:0]       cmp_flags_q;
  logic             cmp_fail, full_cmp;

  logic             running, push_en, pop_en, uf_ev, ovf_ev;

  assign full        = (occ_q == OCC_FULL);
  assign empty       = (occ_q == '0);
  assign head_result = fifo_mem[rptr_q][EW-1:3];
  assign head_flags  = fifo_mem[rptr_q][2:0];

  // Flags are {add, sub, cmp}; add or sub (or no flag at all) means a full-width compare.
  always_comb begin
    full_cmp = cmp_flags_q[2] || cmp_flags_q[1] || !cmp_flags_q[0];
    cmp_fail = 1'b0;
    if (cmp_uf_q)
      cmp_fail = 1'b1;
    else if (full_cmp)
      cmp_fail = (cmp_exp_q != cmp_dut_q);
    else
      cmp_fail = (cmp_exp_q[WIDTH] != cmp_dut_q[WIDTH]) ||
                 ((cmp_exp_q[WIDTH-1:0] == '0) != (cmp_dut_q[WIDTH-1:0] == '0));
  end

`ifdef CHK_STOP_ON_FAIL_EN
  typedef enum logic {ST_RUN, ST_HALT} state_t;
  state_t state_q;
  logic   stop_now;
  // A failing compare freezes the checker in the same cycle it is counted, so nothing behind it is consumed.
  assign stop_now = cmp_vld_q && cmp_fail;
  assign running  = (state_q == ST_RUN) && !stop_now;
  assign halted   = (state_q == ST_HALT);
`else
  assign running  = 1'b1;
  assign halted   = 1'b0;
`endif

  assign pop_en    = dut_valid && running && !empty;
  assign uf_ev     = dut_valid && running && empty;
  assign push_en   = exp_valid && running && (!full || pop_en);
  assign ovf_ev    = exp_valid && running && full && !pop_en;
  assign exp_ready = !full && running;

  always_ff @(posedge clk) begin
    if (push_en)
      fifo_mem[wptr_q] <= {exp_result, exp_add, exp_sub, exp_cmp};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      occ_q          <= '0;
      cmp_vld_q      <= 1'b0;
      cmp_uf_q       <= 1'b0;
      cmp_exp_q      <= '0;
      cmp_dut_q      <= '0;
      cmp_flags_q    <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      mismatch       <= 1'b0;
      first_fail_exp <= '0;
      first_fail_dut <= '0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
`ifdef CHK_STOP_ON_FAIL_EN
      state_q        <= ST_RUN;
`endif
    end else if (clear) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      occ_q          <= '0;
      cmp_vld_q      <= 1'b0;
      cmp_uf_q       <= 1'b0;
      cmp_exp_q      <= '0;
      cmp_dut_q      <= '0;
      cmp_flags_q    <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      mismatch       <= 1'b0;
      first_fail_exp <= '0;
      first_fail_dut <= '0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
`ifdef CHK_STOP_ON_FAIL_EN
      state_q        <= ST_RUN;
`endif
    end else begin
      if (push_en) wptr_q <= wptr_q + AW'(1);
      if (pop_en)  rptr_q <= rptr_q + AW'(1);
      occ_q <= occ_q + OW'(push_en) - OW'(pop_en);
      if (ovf_ev) overflow  <= 1'b1;
      if (uf_ev)  underflow <= 1'b1;

      cmp_vld_q   <= pop_en || uf_ev;
      cmp_uf_q    <= uf_ev;
      cmp_exp_q   <= uf_ev ? '0 : head_result;
      cmp_dut_q   <= dut_result;
      cmp_flags_q <= head_flags;

      mismatch <= cmp_vld_q && cmp_fail;
      if (cmp_vld_q) begin
        if (cmp_fail) begin
          if (fail_count == '0) begin
            first_fail_exp <= cmp_exp_q;
            first_fail_dut <= cmp_dut_q;
          end
          if (fail_count != CNT_MAX) fail_count <= fail_count + CNT_W'(1);
        end else if (pass_count != CNT_MAX) begin
          pass_count <= pass_count + CNT_W'(1);
        end
      end
`ifdef CHK_STOP_ON_FAIL_EN
      if (stop_now) state_q <= ST_HALT;
`endif
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: ordering, compare rules, full/empty corners, reset and clear.
module tb_alu_result_checker;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n, clear;
  logic          exp_valid, exp_add, exp_sub, exp_cmp;
  logic [W:0]    exp_result;
  logic          exp_ready;
  logic          dut_valid;
  logic [W:0]    dut_result;
  logic [15:0]   pass_count, fail_count;
  logic          mismatch;
  logic [W:0]    first_fail_exp, first_fail_dut;
  logic          overflow, underflow, halted;

  int n_checks = 0;
  int n_pass   = 0;

  alu_result_checker #(.WIDTH(W), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .exp_valid(exp_valid), .exp_result(exp_result),
    .exp_add(exp_add), .exp_sub(exp_sub), .exp_cmp(exp_cmp),
    .exp_ready(exp_ready),
    .dut_valid(dut_valid), .dut_result(dut_result),
    .pass_count(pass_count), .fail_count(fail_count), .mismatch(mismatch),
    .first_fail_exp(first_fail_exp), .first_fail_dut(first_fail_dut),
    .overflow(overflow), .underflow(underflow), .halted(halted)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    exp_valid = 1'b0; exp_add = 1'b0; exp_sub = 1'b0; exp_cmp = 1'b0;
    exp_result = '0; dut_valid = 1'b0; dut_result = '0; clear = 1'b0;
  endtask

  task automatic push(input logic [W:0] r, input logic a, input logic s, input logic c);
    exp_valid = 1'b1; exp_result = r; exp_add = a; exp_sub = s; exp_cmp = c;
    tick();
    exp_valid = 1'b0; exp_add = 1'b0; exp_sub = 1'b0; exp_cmp = 1'b0;
  endtask

  task automatic pop(input logic [W:0] r);
    dut_valid = 1'b1; dut_result = r;
    tick();
    dut_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    n_checks++; if (exp_ready !== 1'b1) $display("FAIL reset_exp_ready got %b want 1", exp_ready); else n_pass++;
    n_checks++; if ({pass_count, fail_count} !== 32'd0) $display("FAIL reset_counts got %0d/%0d want 0/0", pass_count, fail_count); else n_pass++;
    n_checks++; if ({mismatch, overflow, underflow, halted} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {mismatch, overflow, underflow, halted}); else n_pass++;
    n_checks++; if ({first_fail_exp, first_fail_dut} !== '0) $display("FAIL reset_capture got %h/%h want 0/0", first_fail_exp, first_fail_dut); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_pass();
    logic seen;
    logic [W:0] vals [3];
    vals[0] = 33'h0_00000003; vals[1] = 33'h1_00000000; vals[2] = 33'h0_FFFFFFFF;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) push(vals[i], 1'b1, 1'b0, 1'b0);
    dut_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dut_result = vals[i];
      tick();
      seen = seen | mismatch;
    end
    dut_valid = 1'b0;
    tick(); seen = seen | mismatch;
    tick(); seen = seen | mismatch;
    n_checks++; if (pass_count !== 16'd3) $display("FAIL add_pass_count got %0d want 3", pass_count); else n_pass++;
    n_checks++; if (fail_count !== 16'd0) $display("FAIL add_fail_count got %0d want 0", fail_count); else n_pass++;
    n_checks++; if (seen !== 1'b0) $display("FAIL add_mismatch_seen got %b want 0", seen); else n_pass++;
    n_checks++; if ({underflow, exp_ready} !== 2'b01) $display("FAIL add_empty got uf=%b rdy=%b want 0/1", underflow, exp_ready); else n_pass++;
  endtask

  task automatic test_sub_fail();
    do_clear();
    push(33'h1_FFFFFFFF, 1'b0, 1'b1, 1'b0);
    pop(33'h0_FFFFFFFF);
    n_checks++; if ({mismatch, fail_count} !== 17'd0) $display("FAIL sub_latency got mm=%b fc=%0d want 0/0", mismatch, fail_count); else n_pass++;
    tick();
    n_checks++; if (mismatch !== 1'b1) $display("FAIL sub_mismatch got %b want 1", mismatch); else n_pass++;
    n_checks++; if (fail_count !== 16'd1) $display("FAIL sub_fail_count got %0d want 1", fail_count); else n_pass++;
    n_checks++; if (first_fail_exp !== 33'h1_FFFFFFFF) $display("FAIL sub_first_exp got %h want 1ffffffff", first_fail_exp); else n_pass++;
    n_checks++; if (first_fail_dut !== 33'h0_FFFFFFFF) $display("FAIL sub_first_dut got %h want 0ffffffff", first_fail_dut); else n_pass++;
    tick();
    n_checks++; if (mismatch !== 1'b0) $display("FAIL sub_pulse_width got %b want 0", mismatch); else n_pass++;
    push(33'h0_00000005, 1'b1, 1'b0, 1'b0);
    pop(33'h0_00000007);
    tick();
    n_checks++; if (fail_count !== 16'd2) $display("FAIL sub_second_count got %0d want 2", fail_count); else n_pass++;
    n_checks++; if ({first_fail_exp, first_fail_dut} !== {33'h1_FFFFFFFF, 33'h0_FFFFFFFF}) $display("FAIL sub_capture_kept got %h/%h want 1ffffffff/0ffffffff", first_fail_exp, first_fail_dut); else n_pass++;
  endtask

  task automatic test_cmp_rules();
    do_clear();
    push(33'h1_00000005, 1'b0, 1'b0, 1'b1);
    pop(33'h1_00000009);
    tick();
    n_checks++; if ({pass_count, fail_count} !== {16'd1, 16'd0}) $display("FAIL cmp_pass got %0d/%0d want 1/0", pass_count, fail_count); else n_pass++;
    push(33'h1_00000005, 1'b0, 1'b0, 1'b1);
    pop(33'h1_00000000);
    tick();
    n_checks++; if (fail_count !== 16'd1) $display("FAIL cmp_zero_fail got %0d want 1", fail_count); else n_pass++;
    // No flags behaves as sub: a cmp-style match is not enough.
    push(33'h0_00000005, 1'b0, 1'b0, 1'b0);
    pop(33'h0_00000004);
    tick();
    n_checks++; if (fail_count !== 16'd2) $display("FAIL noflag_as_sub got %0d want 2", fail_count); else n_pass++;
    // add outranks cmp.
    push(33'h0_00000005, 1'b1, 1'b0, 1'b1);
    pop(33'h0_00000006);
    tick();
    n_checks++; if ({pass_count, fail_count} !== {16'd1, 16'd3}) $display("FAIL add_over_cmp got %0d/%0d want 1/3", pass_count, fail_count); else n_pass++;
  endtask

  task automatic test_full();
    do_clear();
    for (int i = 0; i < 4; i++) push(33'(10 + i), 1'b1, 1'b0, 1'b0);
    n_checks++; if (exp_ready !== 1'b0) $display("FAIL full_ready got %b want 0", exp_ready); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL full_no_ovf_yet got %b want 0", overflow); else n_pass++;
    push(33'd14, 1'b1, 1'b0, 1'b0);
    n_checks++; if (overflow !== 1'b1) $display("FAIL full_overflow got %b want 1", overflow); else n_pass++;
    exp_valid = 1'b1; exp_result = 33'd20; exp_add = 1'b1;
    dut_valid = 1'b1; dut_result = 33'd10;
    tick();
    idle();
    n_checks++; if (exp_ready !== 1'b0) $display("FAIL full_pushpop_ready got %b want 0", exp_ready); else n_pass++;
    pop(33'd11); pop(33'd12); pop(33'd13); pop(33'd20);
    tick();
    n_checks++; if ({pass_count, fail_count} !== {16'd5, 16'd0}) $display("FAIL full_drain got %0d/%0d want 5/0", pass_count, fail_count); else n_pass++;
    n_checks++; if ({exp_ready, underflow} !== 2'b10) $display("FAIL full_after_drain got rdy=%b uf=%b want 1/0", exp_ready, underflow); else n_pass++;
  endtask

  task automatic test_underflow();
    do_clear();
    exp_valid = 1'b1; exp_result = 33'd7; exp_add = 1'b1;
    dut_valid = 1'b1; dut_result = 33'd7;
    tick();
    idle();
    n_checks++; if (underflow !== 1'b1) $display("FAIL uf_flag got %b want 1", underflow); else n_pass++;
    tick();
    n_checks++; if ({mismatch, fail_count} !== {1'b1, 16'd1}) $display("FAIL uf_count got mm=%b fc=%0d want 1/1", mismatch, fail_count); else n_pass++;
    n_checks++; if ({first_fail_exp, first_fail_dut} !== {33'd0, 33'd7}) $display("FAIL uf_capture got %h/%h want 0/7", first_fail_exp, first_fail_dut); else n_pass++;
    pop(33'd7);
    tick();
    n_checks++; if ({pass_count, fail_count} !== {16'd1, 16'd1}) $display("FAIL uf_entry_queued got %0d/%0d want 1/1", pass_count, fail_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_clear();
    push(33'd1, 1'b1, 1'b0, 1'b0);
    pop(33'd1);
    push(33'd2, 1'b1, 1'b0, 1'b0);
    push(33'd3, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++; if (pass_count !== 16'd1) $display("FAIL mid_pre_count got %0d want 1", pass_count); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({pass_count, fail_count, exp_ready} !== {16'd0, 16'd0, 1'b1}) $display("FAIL mid_async got %0d/%0d rdy=%b want 0/0/1", pass_count, fail_count, exp_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    pop(33'd2);
    n_checks++; if (underflow !== 1'b1) $display("FAIL mid_discarded got uf=%b want 1", underflow); else n_pass++;
  endtask

`ifdef CHK_STOP_ON_FAIL_EN
  task automatic test_stop_on_fail();
    do_clear();
    push(33'd1, 1'b0, 1'b1, 1'b0);
    push(33'd2, 1'b1, 1'b0, 1'b0);
    push(33'd3, 1'b1, 1'b0, 1'b0);
    dut_valid = 1'b1;
    dut_result = 33'd9; tick();
    dut_result = 33'd2; tick();
    dut_result = 33'd3; tick();
    dut_valid = 1'b0;
    tick();
    n_checks++; if ({halted, exp_ready} !== 2'b10) $display("FAIL stop_halted got h=%b rdy=%b want 1/0", halted, exp_ready); else n_pass++;
    n_checks++; if ({pass_count, fail_count} !== {16'd0, 16'd1}) $display("FAIL stop_counts got %0d/%0d want 0/1", pass_count, fail_count); else n_pass++;
    do_clear();
    n_checks++; if ({halted, pass_count, fail_count} !== 33'd0) $display("FAIL stop_clear got h=%b %0d/%0d want 0 0/0", halted, pass_count, fail_count); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_add_pass();
    test_sub_fail();
    test_cmp_rules();
    test_full();
    test_underflow();
    test_reset_mid();
`ifdef CHK_STOP_ON_FAIL_EN
    test_stop_on_fail();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
